// File: rtl/zbus_master.sv
// ZX-bus (Z80-style) cycle master.
// Runs one memory or IO read/write cycle per request as T1, T2, [TW...], T3.
// Each T-state lasts TDIV fclk cycles.
// Optional feature: define ZBUS_MASTER_WAIT_EN to honour zwait_n.
// With the macro undefined, zwait_n is ignored: memory cycles take 3 T-states
// and IO cycles take 4.
module zbus_master #(
    parameter int unsigned TDIV = 4
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_io,
    input  logic        req_wr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        zmreq_n,
    output logic        ziorq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        zwait_n
);

    if (TDIV < 2 || TDIV > 16) begin : g_bad_tdiv
        $error("zbus_master: TDIV must be in 2..16");
    end

    localparam logic [3:0] TLast = 4'(TDIV - 1);

    typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3} state_e;

    state_e     state_q, state_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       io_q, wr_q;
    logic       accept, finish, t_last, wait_req, strobe_on;

`ifdef ZBUS_MASTER_WAIT_EN
    assign wait_req = ~zwait_n;
`else
    logic unused_zwait;
    assign unused_zwait = zwait_n;
    assign wait_req     = 1'b0;
`endif

    assign t_last = (tcnt_q == TLast);

    // State register, latched request fields, read data and done pulse
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= StIdle;
            tcnt_q  <= 4'd0;
            za      <= 16'h0000;
            zd_out  <= 8'h00;
            io_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata   <= 8'h00;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            done    <= finish;
            if (accept) begin
                za     <= req_addr;
                zd_out <= req_wdata;
                io_q   <= req_io;
                wr_q   <= req_wr;
            end
            if (finish && !wr_q) begin
                rdata <= zd_in;
            end
        end
    end

    // Next-state logic and T-state counter
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = StT1;
                end
            end
            StT1: begin
                if (t_last) state_d = StT2;
            end
            StT2: begin
                // IO cycles always insert one TW; memory only when the slave asks
                if (t_last) state_d = (io_q || wait_req) ? StTw : StT3;
            end
            StTw: begin
                if (t_last) state_d = wait_req ? StTw : StT3;
            end
            StT3: begin
                if (t_last) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q == StIdle) begin
            tcnt_d = 4'd0;
        end else begin
            tcnt_d = t_last ? 4'd0 : tcnt_q + 4'd1;
        end
    end

    // Bus strobes and status, decoded from the registered state
    always_comb begin
        strobe_on = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
        busy      = (state_q != StIdle);
        zd_oe     = busy && wr_q;
        zmreq_n   = ~(strobe_on && !io_q);
        ziorq_n   = ~(strobe_on && io_q);
        zrd_n     = ~(strobe_on && !wr_q);
        zwr_n     = ~(strobe_on && wr_q);
    end

endmodule

// File: tb/tb_zbus_master.sv
// Scoreboard bench for zbus_master (TDIV=4): the driver pushes expected
// transactions; a negedge monitor checks every bus cycle and each completion.
module tb_zbus_master;
    localparam int unsigned TDIV = 4;

    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        req_io = 1'b0;
    logic        req_wr = 1'b0;
    logic [7:0]  zd_in = 8'h0;
    logic        zwait_n = 1'b1;
    logic        busy, done, zd_oe, zmreq_n, ziorq_n, zrd_n, zwr_n;
    logic [7:0]  rdata, zd_out;
    logic [15:0] za;

    zbus_master #(.TDIV(TDIV)) dut (
        .fclk(fclk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_io(req_io), .req_wr(req_wr),
        .busy(busy), .done(done), .rdata(rdata), .za(za),
        .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in),
        .zmreq_n(zmreq_n), .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
        .zwait_n(zwait_n)
    );

    always #5 fclk = ~fclk;

    // done_cyc < 0 marks a cycle aborted by reset at cycle -done_cyc
    typedef struct {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          lo_last;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done = 0;
    bit   busy_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %h required %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle bus checks and completion checks against the queue head
    always @(negedge fclk) begin : mon
        exp_t e;
        logic lo;
        bit   was_busy;
        was_busy = busy_prev;
        if (busy === 1'b1 && !busy_prev) cyc = 0;
        else cyc = cyc + 1;
        busy_prev = (busy === 1'b1);
        if (done === 1'b1) n_done++;
        if (busy === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL spurious_busy: busy=1 with no cycle expected");
            end else begin
                e  = q[0];
                lo = (cyc >= TDIV) && (cyc <= e.lo_last);
                check("bus_cycle",
                      {done, zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe, za,
                       (e.wr ? zd_out : 8'h00)},
                      {1'b0, !(lo && !e.io), !(lo && e.io), !(lo && !e.wr),
                       !(lo && e.wr), e.wr, e.addr, (e.wr ? e.wdata : 8'h00)});
            end
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL spurious_done: done=1 with no cycle expected");
            end else begin
                e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("done_rdata", rdata, e.exp_rdata);
                check("done_bus", {busy, zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe, za},
                      {1'b0, 4'hF, 1'b0, e.addr});
            end
        end else if (was_busy && q.size() > 0) begin
            e = q.pop_front();
            if (e.done_cyc >= 0) begin
                n_vec++; n_err++;
                $display("FAIL missing_done: busy fell at cycle %0d, required done at %0d",
                         cyc, e.done_cyc);
            end else begin
                check("abort_cycle", 64'(cyc), 64'(-e.done_cyc));
                check("abort_bus", {done, zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe, za, zd_out, rdata},
                      {1'b0, 4'hF, 1'b0, 16'h0000, 8'h00, 8'h00});
            end
        end
    end

    task automatic push(input logic io, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input int lo_last, input int done_cyc);
        exp_t e;
        e.io = io; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.exp_rdata = exp_rdata; e.lo_last = lo_last; e.done_cyc = done_cyc;
        q.push_back(e);
    endtask

    task automatic drive(input logic io, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din);
        req_io = io; req_wr = wr; req_addr = addr; req_wdata = wdata; zd_in = din;
    endtask

    // Returns #1 into cycle 0 of the accepted transaction (DUT must be idle)
    task automatic issue(input logic io, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din,
                         input logic [7:0] exp_rdata, input int lo_last, input int done_cyc);
        push(io, wr, addr, wdata, exp_rdata, lo_last, done_cyc);
        @(posedge fclk); #1;
        drive(io, wr, addr, wdata, din);
        req = 1'b1;
        @(posedge fclk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge fclk); #1;
            if (q.size() == 0 && busy === 1'b0) return;
        end
        n_vec++; n_err++;
        $display("FAIL timeout: %0d entries still pending after %0d cycles", q.size(), bound);
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        check("reset_state",
              {busy, done, rdata, za, zd_out, zd_oe, zmreq_n, ziorq_n, zrd_n, zwr_n},
              {1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 4'hF});
        @(posedge fclk); #1;
        rst = 1'b0;

        // Memory read 0x1234 -> 0x5A, strobes cycles 4..11, done at 12
        issue(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 8'h5A, 11, 12);
        wait_idle(60);

        // IO write 0xABAB data 0x3C, strobes 4..15, done at 16, rdata kept
        issue(1'b1, 1'b1, 16'hABAB, 8'h3C, 8'hFF, 8'h5A, 15, 16);
        wait_idle(60);

        // IO read with zwait_n low over the first two TW samples
`ifdef ZBUS_MASTER_WAIT_EN
        issue(1'b1, 1'b0, 16'h00FE, 8'h00, 8'hC3, 8'hC3, 23, 24);
`else
        issue(1'b1, 1'b0, 16'h00FE, 8'h00, 8'hC3, 8'hC3, 15, 16);
`endif
        repeat (8) @(posedge fclk);
        #1 zwait_n = 1'b0;
        repeat (8) @(posedge fclk);
        #1 zwait_n = 1'b1;
        wait_idle(60);

        // Back-to-back: write then read with req held high
        push(1'b0, 1'b1, 16'h8001, 8'hA5, 8'hC3, 11, 12);
        push(1'b0, 1'b0, 16'h8002, 8'h00, 8'h96, 11, 12);
        @(posedge fclk); #1;
        drive(1'b0, 1'b1, 16'h8001, 8'hA5, 8'h00);
        req = 1'b1;
        @(posedge fclk); #1;
        drive(1'b0, 1'b0, 16'h8002, 8'h00, 8'h96);
        begin : b2b
            int k;
            for (k = 0; k < 40; k++) begin
                @(negedge fclk);
                if (done === 1'b1) break;
            end
            @(posedge fclk); #1;
            req = 1'b0;
            @(negedge fclk); #1;
            check("b2b_restart", busy, 1'b1);
        end
        wait_idle(60);

        // req pulsed while busy must be ignored
        issue(1'b0, 1'b0, 16'h4000, 8'h00, 8'h11, 8'h11, 11, 12);
        repeat (5) @(posedge fclk);
        #1;
        drive(1'b1, 1'b1, 16'hDEAD, 8'hEE, 8'h11);
        req = 1'b1;
        @(posedge fclk); #1;
        req = 1'b0;
        wait_idle(60);
        repeat (12) @(posedge fclk);

        // Reset during cycle 6 of a memory write aborts it
        issue(1'b0, 1'b1, 16'h2222, 8'h77, 8'h00, 8'h00, 11, -7);
        repeat (6) @(posedge fclk);
        #1 rst = 1'b1;
        @(posedge fclk); #1;
        rst = 1'b0;
        wait_idle(60);
        repeat (12) @(posedge fclk);

        // Recovery after reset
        issue(1'b0, 1'b0, 16'h0F0F, 8'h00, 8'hE1, 8'hE1, 11, 12);
        wait_idle(60);
        repeat (4) @(posedge fclk);
        @(negedge fclk); #1;
        check("done_count", 64'(n_done), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zbus_master.md
ZBUS_MASTER -- requirements
Module: zbus_master

Interface
Parameters: name, default, meaning
REQ-001 TDIV, 4, fclk cycles per Z80 T-state; legal range 2..16.
Ports: name, direction, width, meaning
REQ-002 fclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  1  cycle request, sampled only when busy=0.
REQ-005 req_addr  input  16  cycle address.
REQ-006 req_wdata  input  8  write data.
REQ-007 req_io  input  1  1 = IO cycle, 0 = memory cycle.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 busy  output  1  high from acceptance until done.
REQ-010 done  output  1  one-fclk pulse marking cycle end.
REQ-011 rdata  output  8  data captured by the last read.
REQ-012 za  output  16  ZX-bus address.
REQ-013 zd_out, zd_oe, zd_in  output/output/input  8/1/8  split bidirectional data bus.
REQ-014 zmreq_n, ziorq_n, zrd_n, zwr_n  output  1 each  Z80 strobes, active-low.
REQ-015 zwait_n  input  1  wait request from the addressed slave, active-low.

Function
REQ-016 States: IDLE, T1, T2, TW, T3; each T-state lasts exactly TDIV fclk cycles, counted by an internal T-state counter.
REQ-017 IDLE with req=1 at an edge: latch addr, wdata, io and wr; enter T1; busy=1 from the next cycle. Cycle 0 is the first T1 cycle.
REQ-018 T1: za=latched address; all strobes high; zd_oe=1 and zd_out=wdata for writes.
REQ-019 T2 first cycle: assert zmreq_n (memory) or ziorq_n (IO), plus zrd_n or zwr_n; strobes stay low through the last T3 cycle.
REQ-020 Memory cycle: T1, T2, T3. IO cycle: T1, T2, one mandatory TW, then T3.
REQ-021 zwait_n is sampled on the last fclk of T2 (memory) and of each TW (IO or memory); a 0 sample appends one more TW.
REQ-022 Read data: rdata <= zd_in on the last fclk of T3; rdata holds until the next read completes; writes leave rdata unchanged.
REQ-023 After the last T3 cycle: strobes high; zd_oe=0; state IDLE; done=1 for exactly one cycle; busy=0 in that same cycle.
REQ-024 Without waits, done appears at cycle 3*TDIV (memory) or 4*TDIV (IO).
REQ-025 req in the cycle done=1 is accepted, giving back-to-back cycles with one idle fclk between them.
REQ-026 req while busy=1 is ignored and not queued.
REQ-027 za holds the last address while in IDLE.
REQ-028 zmreq_n and ziorq_n are never low simultaneously.
REQ-029 zrd_n and zwr_n are never low simultaneously.
REQ-030 zd_oe=1 only during write cycles.

Reset
REQ-031 rst=1 at an edge forces: state IDLE, za=0, zd_out=0, zd_oe=0, all strobes 1, rdata=0, done=0, busy=0.
REQ-032 rst during an active cycle aborts it: strobes high at the next edge, no done pulse, rdata unchanged from its reset value.

Configuration
REQ-033 Macro ZBUS_MASTER_WAIT_EN defined: zwait_n is honoured per REQ-021 with unlimited extension.
REQ-034 Macro ZBUS_MASTER_WAIT_EN undefined: zwait_n is ignored. Memory cycles always take 3 T-states; IO cycles always take 4.

Verification
REQ-035 TDIV=4, memory read 0x1234, zd_in=0x5A:
- zmreq_n and zrd_n low in cycles 4..11;
- done at cycle 12;
- rdata=0x5A.
REQ-036 TDIV=4, IO write 0xABAB, data 0x3C:
- ziorq_n and zwr_n low in cycles 4..15;
- zd_oe=1 in cycles 0..15 with zd_out=0x3C;
- done at cycle 16.
REQ-037 WAIT_EN defined, TDIV=4, IO read, zwait_n=0 for two TW samples -> three TW states, done at cycle 24.
REQ-038 Back-to-back memory write then read with req held high -> second T1 starts the cycle after the first done, and no strobe overlap.
REQ-039 rst asserted at cycle 6 of a memory write -> all strobes high and zd_oe=0 at the next edge, with no done pulse.
REQ-040 req pulsed while busy=1 -> ignored; only the original cycle runs and only one done pulse appears.
